// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA test-pattern generator: mode
// encoding, the eight colour-bar masks and the default active resolution.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_BOX   = 2'd3
  } mode_e;

  localparam int H_ACTIVE_DEFAULT = 800;
  localparam int V_ACTIVE_DEFAULT = 480;

  // {R,G,B} on/off masks; each set bit becomes an all-ones channel.
  localparam logic [2:0] BAR_WHITE   = 3'b111;
  localparam logic [2:0] BAR_YELLOW  = 3'b110;
  localparam logic [2:0] BAR_CYAN    = 3'b011;
  localparam logic [2:0] BAR_GREEN   = 3'b010;
  localparam logic [2:0] BAR_MAGENTA = 3'b101;
  localparam logic [2:0] BAR_RED     = 3'b100;
  localparam logic [2:0] BAR_BLUE    = 3'b001;
  localparam logic [2:0] BAR_BLACK   = 3'b000;

  function automatic logic [2:0] bar_mask(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position: one step per frame on each axis, reversing
// direction whenever the next step would push the box past the active edge.
module vga_box_mover
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE = V_ACTIVE_DEFAULT,
  parameter int COORD_W  = 10,
  parameter int BOX_SIZE = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step_en,
  output logic [COORD_W-1:0] box_x,
  output logic [COORD_W-1:0] box_y
);

  localparam logic [COORD_W:0] X_MAX = (COORD_W+1)'(H_ACTIVE - BOX_SIZE);
  localparam logic [COORD_W:0] Y_MAX = (COORD_W+1)'(V_ACTIVE - BOX_SIZE);

  logic [COORD_W-1:0] box_x_q, box_x_d, box_y_q, box_y_d;
  logic               dir_x_q, dir_x_d, dir_y_q, dir_y_d;

  // Returns {direction, position}; direction 1 means counting up.
  function automatic logic [COORD_W:0] axis_step(input logic [COORD_W-1:0] pos,
                                                 input logic dir_up,
                                                 input logic [COORD_W:0] max_pos);
    if (dir_up) begin
      if (({1'b0, pos} + 1'b1) > max_pos) return {1'b0, pos - 1'b1};
      return {1'b1, pos + 1'b1};
    end
    if (pos == '0) return {1'b1, pos + 1'b1};
    return {1'b0, pos - 1'b1};
  endfunction

  always_comb begin
    {dir_x_d, box_x_d} = {dir_x_q, box_x_q};
    {dir_y_d, box_y_d} = {dir_y_q, box_y_q};
    if (step_en) begin
      {dir_x_d, box_x_d} = axis_step(box_x_q, dir_x_q, X_MAX);
      {dir_y_d, box_y_d} = axis_step(box_y_q, dir_y_q, Y_MAX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      box_x_q <= '0;
      box_y_q <= '0;
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b1;
    end else begin
      box_x_q <= box_x_d;
      box_y_q <= box_y_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
    end
  end

  assign box_x = box_x_q;
  assign box_y = box_y_q;

endmodule

// File: rtl/vga_pic_gen.sv
// VGA test-pattern generator: key-selected pattern, switched only at frame
// start, with a two-stage registered colour output.
module vga_pic_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE   = V_ACTIVE_DEFAULT,
  parameter int COORD_W    = 10,
  parameter int CH_W       = 8,
  parameter int N_MODES    = 4,
  parameter int CHECK_LOG2 = 5,
  parameter int BOX_SIZE   = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_MODES-1:0]  keyin,
  input  logic [COORD_W-1:0]  pix_x,
  input  logic [COORD_W-1:0]  pix_y,
  output logic [3*CH_W-1:0]   color_data_out,
  output logic [1:0]          mode_out
);

  localparam int               BAR_W = H_ACTIVE / 8;
  localparam logic [COORD_W:0] H_LIM = (COORD_W+1)'(H_ACTIVE);
  localparam logic [COORD_W:0] V_LIM = (COORD_W+1)'(V_ACTIVE);
  localparam logic [COORD_W:0] BOX_W = (COORD_W+1)'(BOX_SIZE);

  logic [N_MODES-1:0] key_q, key_d;
  mode_e              pending_q, pending_d, active_q, active_d;
  logic [3*CH_W-1:0]  pattern_q, pattern_d, color_q, color_d;
  logic [COORD_W:0]   x_ext, y_ext, bx_ext, by_ext;
  logic [COORD_W-1:0] box_x, box_y;
  logic [CH_W-1:0]    grey;
  logic [2:0]         bar_idx;
  logic               frame_start, frame_end, in_active, in_box, checker_on;

  function automatic logic [3*CH_W-1:0] expand_rgb(input logic [2:0] m);
    return {{CH_W{m[2]}}, {CH_W{m[1]}}, {CH_W{m[0]}}};
  endfunction

  assign x_ext       = {1'b0, pix_x};
  assign y_ext       = {1'b0, pix_y};
  assign bx_ext      = {1'b0, box_x};
  assign by_ext      = {1'b0, box_y};
  assign frame_start = (pix_x == '0) && (pix_y == '0);
  assign frame_end   = (x_ext == H_LIM - 1'b1) && (y_ext == V_LIM - 1'b1);
  assign in_active   = (x_ext < H_LIM) && (y_ext < V_LIM);
  assign grey        = pix_x[COORD_W-1 -: CH_W];
  assign checker_on  = pix_x[CHECK_LOG2] ^ pix_y[CHECK_LOG2];
  assign in_box      = (x_ext >= bx_ext) && (x_ext < bx_ext + BOX_W) &&
                       (y_ext >= by_ext) && (y_ext < by_ext + BOX_W);

  vga_box_mover #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .COORD_W  (COORD_W),
    .BOX_SIZE (BOX_SIZE)
  ) u_box_mover (
    .clk     (clk),
    .rst     (rst),
    .step_en (frame_end),
    .box_x   (box_x),
    .box_y   (box_y)
  );

  // Walking downwards lets the lowest rising key overwrite the others.
  // The (0,0) pixel itself already renders in the newly selected mode.
  always_comb begin
    key_d     = keyin;
    pending_d = pending_q;
    for (int i = N_MODES - 1; i >= 0; i--) begin
      if (keyin[i] && !key_q[i]) pending_d = mode_e'(i[1:0]);
    end
    active_d = frame_start ? pending_q : active_q;
  end

  always_comb begin
    bar_idx = '0;
    for (int b = 1; b < 8; b++) begin
      if (x_ext >= (COORD_W+1)'(b * BAR_W)) bar_idx = bar_idx + 3'd1;
    end
  end

  always_comb begin
    pattern_d = '0;
    case (active_d)
      MODE_BARS:  pattern_d = expand_rgb(bar_mask(bar_idx));
      MODE_RAMP:  pattern_d = {grey, grey, grey};
      MODE_CHECK: pattern_d = checker_on ? '1 : '0;
      MODE_BOX:   pattern_d = in_box ? expand_rgb(BAR_RED) : expand_rgb(BAR_BLUE);
      default:    pattern_d = '0;
    endcase
    if (!in_active) pattern_d = '0;
    color_d = pattern_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q     <= '0;
      pending_q <= MODE_BARS;
      active_q  <= MODE_BARS;
      pattern_q <= '0;
      color_q   <= '0;
    end else begin
      key_q     <= key_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      pattern_q <= pattern_d;
      color_q   <= color_d;
    end
  end

  assign color_data_out = color_q;
  assign mode_out       = active_q;

endmodule

// File: tb/tb_vga_pic_gen.sv
// Randomised scoreboard bench for vga_pic_gen against a plain-arithmetic
// model of the pattern, key and bouncing-box rules.
module tb_vga_pic_gen;

  localparam int H    = 800;
  localparam int V    = 480;
  localparam int BOX  = 64;
  localparam int CLOG = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  keyin = '0;
  logic [9:0]  pix_x = '0;
  logic [9:0]  pix_y = '0;
  logic [23:0] color_data_out;
  logic [1:0]  mode_out;

  vga_pic_gen dut (
    .clk            (clk),
    .rst            (rst),
    .keyin          (keyin),
    .pix_x          (pix_x),
    .pix_y          (pix_y),
    .color_data_out (color_data_out),
    .mode_out       (mode_out)
  );

  always #5 clk = ~clk;

  logic [23:0] exp_color_q[$];
  logic [1:0]  exp_mode_q[$];
  string       exp_tag_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference state
  int         m_active = 0, m_pending = 0;
  logic [3:0] m_prev = '0;
  int         m_bx = 0, m_by = 0, m_dx = 1, m_dy = 1;

  function automatic logic [23:0] barColor(input int idx);
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] modelColor(input int x, input int y, input int mode,
                                             input int bx, input int by);
    logic [7:0] g;
    if (x >= H || y >= V) return 24'h0;
    case (mode)
      0: return barColor(x / (H / 8));
      1: begin
        g = 8'(x / 4);
        return {g, g, g};
      end
      2: return ((((x >> CLOG) ^ (y >> CLOG)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      default:
        return (x >= bx && x < bx + BOX && y >= by && y < by + BOX) ? 24'hFF0000 : 24'h0000FF;
    endcase
  endfunction

  task automatic moveBox();
    m_bx += m_dx;
    if (m_bx < 0 || m_bx + BOX > H) begin m_dx = -m_dx; m_bx += 2 * m_dx; end
    m_by += m_dy;
    if (m_by < 0 || m_by + BOX > V) begin m_dy = -m_dy; m_by += 2 * m_dy; end
  endtask

  // One pixel per clock: drive inputs, advance the model, queue the expectation.
  task automatic applyStimulus(input int x, input int y, input logic [3:0] k,
                               input logic r, input string tag);
    int xe, ye;
    logic [3:0] rise;
    logic [23:0] c;
    @(posedge clk);
    #1;
    if (r && !rst) begin
      exp_color_q.delete();
      exp_mode_q.delete();
      exp_tag_q.delete();
    end
    xe = x & 1023;
    ye = y & 1023;
    rst = r; keyin = k; pix_x = xe[9:0]; pix_y = ye[9:0];
    if (r) begin
      m_active = 0; m_pending = 0; m_prev = '0;
      m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
      c = 24'h0;
    end else begin
      if (xe == 0 && ye == 0) m_active = m_pending;
      c = modelColor(xe, ye, m_active, m_bx, m_by);
      rise = k & ~m_prev;
      for (int i = 0; i < 4; i++) begin
        if (rise[i]) begin m_pending = i; break; end
      end
      m_prev = k;
      if (xe == H - 1 && ye == V - 1) moveBox();
    end
    exp_color_q.push_back(c);
    exp_mode_q.push_back(2'(m_active));
    exp_tag_q.push_back(tag);
  endtask

  // Colour lags the sample by two cycles; mode_out reflects the previous sample.
  task automatic checkOutput();
    n_checks++;
    if (color_data_out !== exp_color_q[0]) begin
      n_fail++;
      $display("[TB] FAIL color %s: got %06h expected %06h", exp_tag_q[0], color_data_out, exp_color_q[0]);
    end
    n_checks++;
    if (mode_out !== exp_mode_q[1]) begin
      n_fail++;
      $display("[TB] FAIL mode %s: got %0d expected %0d", exp_tag_q[1], mode_out, exp_mode_q[1]);
    end
    void'(exp_color_q.pop_front());
    void'(exp_mode_q.pop_front());
    void'(exp_tag_q.pop_front());
  endtask

  always @(negedge clk) begin
    if (exp_color_q.size() >= 3) checkOutput();
  end

  task automatic randomPixel(input logic [3:0] k, input string tag);
    applyStimulus($urandom_range(0, H - 2), $urandom_range(1, V - 2), k, 1'b0, tag);
  endtask

  task automatic newFrame(input logic [3:0] k);
    applyStimulus(H - 1, V - 1, k, 1'b0, "frame_end");
    applyStimulus(0, 0, k, 1'b0, "frame_start");
  endtask

  initial begin
    logic [3:0] k;
    int sel;
    $display("[TB] start");
    repeat (3) applyStimulus(5, 5, 4'b0000, 1'b1, "reset");

    applyStimulus(0, 0, 4'b0000, 1'b0, "bars(0,0)");
    applyStimulus(100, 0, 4'b0000, 1'b0, "bars(100,0)");
    applyStimulus(799, 10, 4'b0000, 1'b0, "bars(799,10)");
    for (int b = 0; b < 8; b++) begin
      applyStimulus(b * 100, 7, 4'b0000, 1'b0, "bar_left");
      applyStimulus(b * 100 + 99, 300, 4'b0000, 1'b0, "bar_right");
    end
    repeat (10) randomPixel(4'b0000, "bars_rand");

    repeat (3) randomPixel(4'b0001, "key0001");
    applyStimulus(400, 200, 4'b0100, 1'b0, "key0100");
    repeat (20) randomPixel(4'b0100, "hold_mode0");
    newFrame(4'b0100);
    applyStimulus(32, 0, 4'b0100, 1'b0, "check(32,0)");
    applyStimulus(0, 32, 4'b0100, 1'b0, "check(0,32)");
    applyStimulus(32, 32, 4'b0100, 1'b0, "check(32,32)");
    repeat (10) randomPixel(4'b0100, "check_rand");

    applyStimulus(10, 10, 4'b0000, 1'b0, "key_clear");
    applyStimulus(11, 10, 4'b0110, 1'b0, "key0110");
    repeat (5) randomPixel(4'b0110, "check_rand2");
    newFrame(4'b0110);
    applyStimulus(400, 5, 4'b0110, 1'b0, "ramp(400,5)");
    repeat (10) randomPixel(4'b0110, "ramp_rand");

    applyStimulus(10, 10, 4'b0000, 1'b0, "key_clear");
    applyStimulus(11, 10, 4'b1000, 1'b0, "key1000");
    newFrame(4'b1000);
    for (int f = 0; f < 740; f++) begin
      applyStimulus(m_bx, m_by, 4'b1000, 1'b0, "box_corner");
      applyStimulus(m_bx + BOX, m_by, 4'b1000, 1'b0, "box_right_out");
      applyStimulus(m_bx - 1, m_by, 4'b1000, 1'b0, "box_left_out");
      applyStimulus(m_bx + BOX - 1, m_by + BOX - 1, 4'b1000, 1'b0, "box_far");
      randomPixel(4'b1000, "box_rand");
      newFrame(4'b1000);
    end

    repeat (5) randomPixel(4'b1000, "pre_reset");
    repeat (4) applyStimulus(300, 300, 4'b0000, 1'b1, "mid_reset");
    repeat (4) randomPixel(4'b0000, "post_reset");
    applyStimulus(20, 20, 4'b1000, 1'b0, "key_box");
    applyStimulus(0, 0, 4'b1000, 1'b0, "box_home(0,0)");
    applyStimulus(64, 0, 4'b1000, 1'b0, "box_home(64,0)");
    applyStimulus(63, 63, 4'b1000, 1'b0, "box_home(63,63)");

    applyStimulus(810, 10, 4'b1000, 1'b0, "out(810,10)");
    applyStimulus(10, 480, 4'b1000, 1'b0, "out(10,480)");
    applyStimulus(1023, 1023, 4'b1000, 1'b0, "out(1023,1023)");

    k = 4'b1000;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 15) == 0) k = 4'($urandom_range(0, 15));
      sel = $urandom_range(0, 49);
      if ($urandom_range(0, 499) == 0) begin
        repeat (2) applyStimulus(1, 1, 4'b0000, 1'b1, "rand_reset");
        k = 4'b0000;
      end else if (sel == 0) applyStimulus(H - 1, V - 1, k, 1'b0, "rand_frame_end");
      else if (sel == 1) applyStimulus(0, 0, k, 1'b0, "rand_frame_start");
      else if (sel == 2) applyStimulus($urandom_range(0, 1023), $urandom_range(0, 1023), k, 1'b0, "rand_any");
      else randomPixel(k, "rand_pix");
    end

    repeat (3) applyStimulus(1000, 1000, k, 1'b0, "drain");
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_pic_gen.md
VGA_PIC_GEN -- requirements
Module: vga_pic_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 800, active pixels per line; must be divisible by 8.
REQ-002 SHALL have parameter V_ACTIVE, default 480, active lines per frame.
REQ-003 SHALL have parameter COORD_W, default 10, width of the pixel coordinates.
REQ-004 SHALL have parameter CH_W, default 8, width of each colour channel; colour word is 3*CH_W wide, ordered {R,G,B}.
REQ-005 SHALL have parameter N_MODES, default 4, number of patterns and keyin width; range 1..4.
REQ-006 SHALL have parameter CHECK_LOG2, default 5, checker square edge of 2**CHECK_LOG2 pixels.
REQ-007 SHALL have parameter BOX_SIZE, default 64, moving-box edge in pixels; BOX_SIZE < V_ACTIVE.
REQ-008 clk  in  1  pixel clock; one clock, all state on its rising edge.
REQ-009 rst  in  1  reset, asynchronous and active-high.
REQ-010 keyin  in  N_MODES  debounced mode keys; bit i selects mode i.
REQ-011 pix_x  in  COORD_W  current pixel column, 0..H_ACTIVE-1, advancing by one per clock.
REQ-012 pix_y  in  COORD_W  current pixel row, 0..V_ACTIVE-1.
REQ-013 color_data_out  out  3*CH_W  pixel colour.
REQ-014 mode_out  out  2  currently active mode, for status display.

Function
REQ-015 Output SHALL be registered with a fixed 2-cycle latency from the pix_x/pix_y sample to color_data_out.
REQ-016 Coordinates outside the active area (pix_x >= H_ACTIVE or pix_y >= V_ACTIVE) SHALL produce colour 0.
REQ-017 Mode 0: 8 vertical bars, each H_ACTIVE/8 wide, left to right white, yellow, cyan, green, magenta, red, blue, black (full scale = all channel bits 1).
REQ-018 Mode 1: horizontal grey ramp; R=G=B=pix_x[COORD_W-1 -: CH_W].
REQ-019 Mode 2: checkerboard; white when pix_x[CHECK_LOG2] XOR pix_y[CHECK_LOG2] is 1, else black.
REQ-020 Mode 3: red where box_x <= pix_x < box_x+BOX_SIZE and box_y <= pix_y < box_y+BOX_SIZE, blue elsewhere.
REQ-021 A rising edge on keyin bit i (i < N_MODES) SHALL latch i into pending_mode; simultaneous rising edges: lowest index wins; a later edge before the frame start overwrites pending_mode.
REQ-022 active_mode SHALL load pending_mode only in the cycle (0,0) is presented; that pixel and all others in the frame use the new mode (no mid-frame tearing).
REQ-023 The box position SHALL update once per frame, in the cycle (H_ACTIVE-1, V_ACTIVE-1) is presented, regardless of active mode.
REQ-024 Per axis, step is +1/-1 by direction flag; if the next position would put the box edge outside [0, H_ACTIVE) or [0, V_ACTIVE), direction flips and the position steps the other way in that same update.
REQ-025 mode_out SHALL equal active_mode.

Reset
REQ-026 While rst is high: color_data_out=0, mode_out=0, active_mode=pending_mode=0, box at (0,0), both directions +1, key edge register=0.
REQ-027 Reset mid-frame SHALL take effect immediately; after release, the pipeline restarts with no stale colour output (first 2 cycles output 0).

Structure
REQ-028 Shared package vga_pkg SHALL hold the mode enumeration, the 8 bar colour constants, and default H_ACTIVE/V_ACTIVE.
REQ-029 Box position and direction logic SHALL be a sub-module vga_box_mover; key edge detection and pattern mux stay in vga_pic_gen.

Verification
REQ-030 Reset, keyin=0, full 800x480 scan -> mode 0; pixel (0,0) = 0xFFFFFF, (100,0) = 0xFFFF00, (799,10) = 0x000000, each two cycles after the sample.
REQ-031 keyin 0001->0100 at (400,200) -> mode_out stays 0 to end of frame, becomes 2 at next (0,0); (32,0) = 0xFFFFFF, (0,0) = 0x000000.
REQ-032 keyin 0000->0110 in one cycle -> pending 1; next frame (400,5) = 0x646464.
REQ-033 Mode 3, 740 frames -> box_x reaches 736 at frame 736, then decreases to 735; box_y bounces at 416; (box_x,box_y) pixel red, (box_x+64,box_y) blue.
REQ-034 rst pulsed mid-frame in mode 3 -> color_data_out 0 during reset and the two cycles after; mode_out 0; box at (0,0).
REQ-035 pix_x=810, pix_y=10 presented -> color_data_out 0.
